// File: rtl/umi_demux_if.sv
// Bundled UMI handshake for a 1:N demux: one input stream, N flattened output streams.
// master drives the input side and consumes the outputs; slave is the demux itself.
interface umi_demux_if #(
    parameter int unsigned UW = 256,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned N  = 4
);
    logic            umi_in_valid;
    logic [CW-1:0]   umi_in_cmd;
    logic [AW-1:0]   umi_in_dst_addr;
    logic [AW-1:0]   umi_in_src_addr;
    logic [UW-1:0]   umi_in_payload;
    logic            umi_in_ready;

    logic [N-1:0]    umi_out_valid;
    logic [N-1:0]    umi_out_ready;
    logic [N*CW-1:0] umi_out_cmd;
    logic [N*AW-1:0] umi_out_dst_addr;
    logic [N*AW-1:0] umi_out_src_addr;
    logic [N*UW-1:0] umi_out_payload;

    modport master (
        output umi_in_valid,
        output umi_in_cmd,
        output umi_in_dst_addr,
        output umi_in_src_addr,
        output umi_in_payload,
        input  umi_in_ready,
        input  umi_out_valid,
        output umi_out_ready,
        input  umi_out_cmd,
        input  umi_out_dst_addr,
        input  umi_out_src_addr,
        input  umi_out_payload
    );

    modport slave (
        input  umi_in_valid,
        input  umi_in_cmd,
        input  umi_in_dst_addr,
        input  umi_in_src_addr,
        input  umi_in_payload,
        output umi_in_ready,
        output umi_out_valid,
        input  umi_out_ready,
        output umi_out_cmd,
        output umi_out_dst_addr,
        output umi_out_src_addr,
        output umi_out_payload
    );
endinterface

// File: rtl/umi_demux.sv
// 1:N UMI demux: the port is picked from a dst_addr field, each port has a one-entry output
// register, and packets addressed past the last port are swallowed and counted.
module umi_demux #(
    parameter int unsigned UW     = 256,
    parameter int unsigned CW     = 32,
    parameter int unsigned AW     = 64,
    parameter int unsigned N      = 4,
    parameter int unsigned SELLSB = 40,
    parameter int unsigned DCW    = 16
) (
    input  logic           clk,
    input  logic           reset,
    umi_demux_if.slave     umi,
    output logic           drop_err,
    output logic [DCW-1:0] drop_count
);
    localparam int unsigned SELW = $clog2(N);
    localparam logic [DCW-1:0] CNT_ONE = {{(DCW - 1){1'b0}}, 1'b1};

    logic [SELW-1:0] sel;
    logic            hit;
    logic            sel_full;
    logic            sel_ready;
    logic            in_ready;
    logic            acc;
    logic            drop;
    logic [N-1:0]    load;

    logic [N-1:0]    full_q;
    logic [CW-1:0]   cmd_q     [N];
    logic [AW-1:0]   dst_q     [N];
    logic [AW-1:0]   src_q     [N];
    logic [UW-1:0]   payload_q [N];
    logic            drop_err_q;
    logic [DCW-1:0]  drop_count_q;

    assign sel = umi.umi_in_dst_addr[SELLSB +: SELW];

    // hit and the selected slot's status come from an unrolled match so that indices past N-1
    // (non power-of-two N) never address a missing slot.
    always_comb begin
        hit       = 1'b0;
        sel_full  = 1'b0;
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(sel) == i) begin
                hit       = 1'b1;
                sel_full  = full_q[i];
                sel_ready = umi.umi_out_ready[i];
            end
        end
        in_ready = ~hit | ~sel_full | sel_ready;
        acc      = umi.umi_in_valid & in_ready;
        drop     = acc & ~hit;
        load     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            load[i] = acc & (32'(sel) == i);
        end
    end

    assign umi.umi_in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q       <= '0;
            drop_err_q   <= 1'b0;
            drop_count_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cmd_q[i]     <= '0;
                dst_q[i]     <= '0;
                src_q[i]     <= '0;
                payload_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                // A load wins over a drain so a port can move one packet every cycle.
                if (load[i]) begin
                    full_q[i]    <= 1'b1;
                    cmd_q[i]     <= umi.umi_in_cmd;
                    dst_q[i]     <= umi.umi_in_dst_addr;
                    src_q[i]     <= umi.umi_in_src_addr;
                    payload_q[i] <= umi.umi_in_payload;
                end else if (umi.umi_out_ready[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            drop_err_q <= drop;
            if (drop && (drop_count_q != {DCW{1'b1}})) begin
                drop_count_q <= drop_count_q + CNT_ONE;
            end
        end
    end

    assign umi.umi_out_valid = full_q;
    assign drop_err          = drop_err_q;
    assign drop_count        = drop_count_q;

    for (genvar g = 0; g < N; g++) begin : g_port
        assign umi.umi_out_cmd[g*CW +: CW]      = cmd_q[g];
        assign umi.umi_out_dst_addr[g*AW +: AW] = dst_q[g];
        assign umi.umi_out_src_addr[g*AW +: AW] = src_q[g];
        assign umi.umi_out_payload[g*UW +: UW]  = payload_q[g];
    end
endmodule

// File: tb/tb_umi_demux.sv
// Bench for umi_demux: an N=4 instance for routing/backpressure and an N=3, DCW=2 instance
// for the drop path. Accepted packets are queued per port and matched as ports drain.
module tb_umi_demux;
    localparam int unsigned UW = 256;
    localparam int unsigned CW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned PW = CW + 2 * AW + UW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    umi_demux_if #(.UW(UW), .CW(CW), .AW(AW), .N(4)) u4 ();
    umi_demux_if #(.UW(UW), .CW(CW), .AW(AW), .N(3)) u3 ();

    logic        drop_err4;
    logic [15:0] drop_count4;
    logic        drop_err3;
    logic [1:0]  drop_count3;

    umi_demux #(.UW(UW), .CW(CW), .AW(AW), .N(4), .SELLSB(40), .DCW(16)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .umi        (u4),
        .drop_err   (drop_err4),
        .drop_count (drop_count4)
    );

    umi_demux #(.UW(UW), .CW(CW), .AW(AW), .N(3), .SELLSB(40), .DCW(2)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .umi        (u3),
        .drop_err   (drop_err3),
        .drop_count (drop_count3)
    );

    logic [PW-1:0] exp_q [4][$];
    logic [PW-1:0] hold_data [4];
    logic [3:0]    hold_prev = '0;
    logic [PW-1:0] mon_got;
    logic [PW-1:0] mon_exp;
    bit            stream_done;

    function automatic logic [PW-1:0] pkt(input int unsigned sel, input logic [UW-1:0] pl);
        logic [CW-1:0] c;
        logic [AW-1:0] d;
        logic [AW-1:0] s;
        c = 32'hC000_0000 | 32'(pl[15:0]);
        d = (64'(sel) << 40) | 64'h0000_0000_CDEF_0000 | 64'(pl[15:0]);
        s = 64'h0000_0055_0000_0000 + 64'(pl[31:0]);
        return {c, d, s, pl};
    endfunction

    // Port monitor: held data must stay put, every completed transfer must match the queue head.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                mon_got = {u4.umi_out_cmd[i*CW +: CW], u4.umi_out_dst_addr[i*AW +: AW],
                           u4.umi_out_src_addr[i*AW +: AW], u4.umi_out_payload[i*UW +: UW]};
                if (hold_prev[i]) begin
                    total++;
                    if (u4.umi_out_valid[i] !== 1'b1 || mon_got !== hold_data[i]) begin
                        bad++;
                        $display("FAIL hold port%0d valid=%b data=%h required valid=1 data=%h",
                                 i, u4.umi_out_valid[i], mon_got[UW-1:0], hold_data[i][UW-1:0]);
                    end
                end
                if (u4.umi_out_valid[i] === 1'b1 && u4.umi_out_ready[i] === 1'b1) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL extra_out port%0d got payload %h required no packet",
                                 i, mon_got[UW-1:0]);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        if (mon_got !== mon_exp) begin
                            bad++;
                            $display("FAIL out_data port%0d got %h required %h",
                                     i, mon_got[UW-1:0], mon_exp[UW-1:0]);
                        end
                    end
                end
                hold_prev[i] = (u4.umi_out_valid[i] === 1'b1) && (u4.umi_out_ready[i] !== 1'b1);
                hold_data[i] = mon_got;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one packet to the N=4 instance until accepted (bounded) and queues its expectation.
    task automatic send4(input int unsigned sel, input logic [UW-1:0] pl, output int waited);
        u4.umi_in_valid = 1'b1;
        {u4.umi_in_cmd, u4.umi_in_dst_addr, u4.umi_in_src_addr, u4.umi_in_payload} = pkt(sel, pl);
        waited = 0;
        @(negedge clk);
        while (u4.umi_in_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (u4.umi_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout sel=%0d in_ready=%b required 1", sel, u4.umi_in_ready);
        end else begin
            exp_q[sel].push_back(pkt(sel, pl));
        end
        tick();
        u4.umi_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        u4.umi_in_valid = 1'b0;
        {u4.umi_in_cmd, u4.umi_in_dst_addr, u4.umi_in_src_addr, u4.umi_in_payload} = '0;
        u4.umi_out_ready = 4'b1111;
        u3.umi_in_valid = 1'b0;
        {u3.umi_in_cmd, u3.umi_in_dst_addr, u3.umi_in_src_addr, u3.umi_in_payload} = '0;
        u3.umi_out_ready = 3'b111;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        total++;
        if (u4.umi_out_valid !== 4'b0000 || u3.umi_out_valid !== 3'b000) begin
            bad++;
            $display("FAIL reset_valid got %b/%b required 0000/000", u4.umi_out_valid,
                     u3.umi_out_valid);
        end
        total++;
        if (u4.umi_in_ready !== 1'b1 || u3.umi_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b/%b required 1/1", u4.umi_in_ready, u3.umi_in_ready);
        end
        total++;
        if (drop_err4 !== 1'b0 || drop_count4 !== 16'd0 || drop_err3 !== 1'b0
            || drop_count3 !== 2'd0) begin
            bad++;
            $display("FAIL reset_drop got err=%b/%b cnt=%0d/%0d required 0/0 0/0",
                     drop_err4, drop_err3, drop_count4, drop_count3);
        end
        total++;
        if (u4.umi_out_payload !== '0 || u4.umi_out_cmd !== '0) begin
            bad++;
            $display("FAIL reset_data got payload %h required 0", u4.umi_out_payload);
        end
    endtask

    task automatic test_fanout();
        int w;
        logic [UW-1:0] pl;
        u4.umi_out_ready = 4'b1111;
        for (int unsigned i = 0; i < 4; i++) begin
            pl = UW'(32'hA0 + i);
            send4(i, pl, w);
            total++;
            if (w != 0) begin
                bad++;
                $display("FAIL fanout_ready sel=%0d waited=%0d required 0", i, w);
            end
            total++;
            if (u4.umi_out_valid !== (4'b0001 << i)) begin
                bad++;
                $display("FAIL fanout_valid sel=%0d got %b required %b", i, u4.umi_out_valid,
                         4'b0001 << i);
            end
            total++;
            if (u4.umi_out_payload[i*UW +: UW] !== pl) begin
                bad++;
                $display("FAIL fanout_payload sel=%0d got %h required %h", i,
                         u4.umi_out_payload[i*UW +: UW], pl);
            end
        end
        tick();
        total++;
        if (drop_count4 !== 16'd0 || u4.umi_out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL fanout_tail cnt=%0d valid=%b required 0 0000", drop_count4,
                     u4.umi_out_valid);
        end
    endtask

    task automatic test_backpressure();
        int w;
        u4.umi_out_ready = 4'b1011;
        send4(2, UW'(32'h11), w);
        u4.umi_in_valid = 1'b1;
        {u4.umi_in_cmd, u4.umi_in_dst_addr, u4.umi_in_src_addr, u4.umi_in_payload} =
            pkt(2, UW'(32'h22));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (u4.umi_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready_stall got %b required 0", u4.umi_in_ready);
            end
            tick();
            total++;
            if (u4.umi_out_valid[2] !== 1'b1 || u4.umi_out_payload[2*UW +: UW] !== UW'(32'h11)) begin
                bad++;
                $display("FAIL bp_slot_hold got valid=%b data=%h required 1 11",
                         u4.umi_out_valid[2], u4.umi_out_payload[2*UW +: UW]);
            end
        end
        u4.umi_out_ready = 4'b1111;
        @(negedge clk);
        total++;
        if (u4.umi_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_release got %b required 1", u4.umi_in_ready);
        end else begin
            exp_q[2].push_back(pkt(2, UW'(32'h22)));
        end
        tick();
        u4.umi_in_valid = 1'b0;
        total++;
        if (u4.umi_out_valid[2] !== 1'b1 || u4.umi_out_payload[2*UW +: UW] !== UW'(32'h22)) begin
            bad++;
            $display("FAIL bp_reload got valid=%b data=%h required 1 22",
                     u4.umi_out_valid[2], u4.umi_out_payload[2*UW +: UW]);
        end
        repeat (2) tick();
    endtask

    task automatic test_independence();
        int w;
        u4.umi_out_ready = 4'b1011;
        send4(2, UW'(32'h44), w);
        send4(1, UW'(32'h33), w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL indep_ready waited=%0d required 0", w);
        end
        total++;
        if (u4.umi_out_valid[1] !== 1'b1 || u4.umi_out_payload[1*UW +: UW] !== UW'(32'h33)) begin
            bad++;
            $display("FAIL indep_port1 got valid=%b data=%h required 1 33",
                     u4.umi_out_valid[1], u4.umi_out_payload[1*UW +: UW]);
        end
        total++;
        if (u4.umi_out_valid[2] !== 1'b1 || u4.umi_out_payload[2*UW +: UW] !== UW'(32'h44)) begin
            bad++;
            $display("FAIL indep_port2 got valid=%b data=%h required 1 44",
                     u4.umi_out_valid[2], u4.umi_out_payload[2*UW +: UW]);
        end
        u4.umi_out_ready = 4'b1111;
        repeat (2) tick();
    endtask

    task automatic test_stream();
        int w;
        stream_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send4(0, UW'(32'hB0 + k), w);
                end
                stream_done = 1'b1;
            end
            begin
                int n = 0;
                while (!stream_done && n < 400) begin
                    u4.umi_out_ready[0] = ~u4.umi_out_ready[0];
                    tick();
                    n++;
                end
            end
        join
        u4.umi_out_ready = 4'b1111;
        repeat (3) tick();
        total++;
        if (exp_q[0].size() != 0) begin
            bad++;
            $display("FAIL stream_loss pending=%0d required 0", exp_q[0].size());
        end
    endtask

    task automatic test_drop();
        logic [1:0] exp_cnt;
        u3.umi_in_valid = 1'b1;
        {u3.umi_in_cmd, u3.umi_in_dst_addr, u3.umi_in_src_addr, u3.umi_in_payload} =
            pkt(3, UW'(32'hD0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (u3.umi_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL drop_ready k=%0d got %b required 1", k, u3.umi_in_ready);
            end
            tick();
            exp_cnt = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            total++;
            if (drop_err3 !== 1'b1 || drop_count3 !== exp_cnt || u3.umi_out_valid !== 3'b000) begin
                bad++;
                $display("FAIL drop_pulse k=%0d err=%b cnt=%0d valid=%b required 1 %0d 000",
                         k, drop_err3, drop_count3, u3.umi_out_valid, exp_cnt);
            end
        end
        u3.umi_in_valid = 1'b0;
        tick();
        total++;
        if (drop_err3 !== 1'b0 || drop_count3 !== 2'd3) begin
            bad++;
            $display("FAIL drop_end err=%b cnt=%0d required 0 3", drop_err3, drop_count3);
        end
        u3.umi_in_valid = 1'b1;
        {u3.umi_in_cmd, u3.umi_in_dst_addr, u3.umi_in_src_addr, u3.umi_in_payload} =
            pkt(2, UW'(32'hE2));
        tick();
        u3.umi_in_valid = 1'b0;
        total++;
        if (u3.umi_out_valid !== 3'b100 || u3.umi_out_payload[2*UW +: UW] !== UW'(32'hE2)
            || drop_err3 !== 1'b0) begin
            bad++;
            $display("FAIL n3_hit valid=%b data=%h err=%b required 100 e2 0", u3.umi_out_valid,
                     u3.umi_out_payload[2*UW +: UW], drop_err3);
        end
        total++;
        if (drop_count4 !== 16'd0) begin
            bad++;
            $display("FAIL n4_no_drop cnt=%0d required 0", drop_count4);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int w;
        u4.umi_out_ready = 4'b1101;
        send4(1, UW'(32'h55), w);
        total++;
        if (u4.umi_out_valid[1] !== 1'b1) begin
            bad++;
            $display("FAIL mreset_load got %b required 1", u4.umi_out_valid[1]);
        end
        exp_q[1].delete();
        reset = 1'b1;
        u4.umi_in_valid = 1'b1;
        {u4.umi_in_cmd, u4.umi_in_dst_addr, u4.umi_in_src_addr, u4.umi_in_payload} =
            pkt(0, UW'(32'h66));
        tick();
        total++;
        if (u4.umi_out_valid !== 4'b0000 || drop_count4 !== 16'd0 || drop_count3 !== 2'd0) begin
            bad++;
            $display("FAIL mreset_clear valid=%b cnt4=%0d cnt3=%0d required 0000 0 0",
                     u4.umi_out_valid, drop_count4, drop_count3);
        end
        reset = 1'b0;
        u4.umi_in_valid = 1'b0;
        u4.umi_out_ready = 4'b1111;
        repeat (3) tick();
        total++;
        if (u4.umi_out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL mreset_stale valid=%b required 0000", u4.umi_out_valid);
        end
    endtask

    task automatic test_drain_all();
        for (int unsigned i = 0; i < 4; i++) begin
            total++;
            if (exp_q[i].size() != 0) begin
                bad++;
                $display("FAIL pending port%0d left=%0d required 0", i, exp_q[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fanout();
        test_backpressure();
        test_independence();
        test_stream();
        test_drop();
        test_mid_reset();
        test_drain_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
